// File: rtl/lcd_pkg.sv
// Shared types and default timing for the HD44780-style LCD bus reader.
// Holds the transaction state enum, 50 MHz timing defaults, status-byte
// field positions and a small max helper used to size the phase timer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HIGH,
        E_LOW,
        DONE
    } state_e;

    // Default phase lengths in CLOCK_50 cycles
    localparam int unsigned T_AS_DEF      = 7;
    localparam int unsigned T_EH_DEF      = 23;
    localparam int unsigned T_EL_DEF      = 27;
    localparam int unsigned MAX_POLLS_DEF = 1023;

    // Status byte layout: busy flag on top, address counter below
    localparam int unsigned BF_BIT   = 7;
    localparam int unsigned ADDR_MSB = 6;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by all timed phases of the reader.
// Ports: clk/rst (async active-high), load + load_val restart the count,
//        zero_c flags the last cycle of the current phase.
module lcd_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Loaded with length-1 so zero_c marks the final cycle of the phase
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_read_ctrl.sv
// HD44780-style LCD bus reader: single status/data read cycles, with an
// optional busy-flag poll that re-reads status until BF=0 or MAX_POLLS.
// Ports: CLOCK_50/RST clock and async reset; iREQ/iRS/iPOLL request;
//        oBUSY bus ownership; oVALID/oDATA/oBF/oADDR/oTIMEOUT result;
//        LCD_RW/LCD_RS/LCD_E bus strobes; DATA_BUS sampled, never driven.
// Build option: LCD_READ_SYNC_EN inserts a 2-flop synchroniser on DATA_BUS.
module lcd_read_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS      = T_AS_DEF,
    parameter int unsigned T_EH      = T_EH_DEF,
    parameter int unsigned T_EL      = T_EL_DEF,
    parameter int unsigned MAX_POLLS = MAX_POLLS_DEF
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       iREQ,
    input  logic       iRS,
    input  logic       iPOLL,
    output logic       oBUSY,
    output logic       oVALID,
    output logic [7:0] oDATA,
    output logic       oBF,
    output logic [6:0] oADDR,
    output logic       oTIMEOUT,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_E,
    inout  wire  [7:0] DATA_BUS
);

    localparam int unsigned TMR_W  = $clog2(max3(T_AS, T_EH, T_EL) + 1);
    localparam int unsigned PCNT_W = $clog2(MAX_POLLS + 1);

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                rs_lat_q, rs_lat_d;
    logic                poll_lat_q, poll_lat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                bf_q, bf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                e_q, e_d;
    logic                rs_q, rs_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero_c;
    logic [DATA_W-1:0]   sample_c;

    // The reader only listens on the bus
    assign DATA_BUS = 8'bz;

`ifdef LCD_READ_SYNC_EN
    logic [DATA_W-1:0] sync1_q;
    logic [DATA_W-1:0] sync2_q;

    // Capture sees the bus as it was two cycles earlier
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= DATA_BUS;
            sync2_q <= sync1_q;
        end
    end

    assign sample_c = sync2_q;

    // E must stay high long enough for data to traverse the synchroniser
    if (T_EH < 3) begin : g_teh_check
        $error("lcd_read_ctrl: T_EH must be >= 3 with LCD_READ_SYNC_EN");
    end
`else
    assign sample_c = DATA_BUS;
`endif

    lcd_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (CLOCK_50),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, result capture and registered bus strobes
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        rs_lat_d   = rs_lat_q;
        poll_lat_d = poll_lat_q;
        data_d     = data_q;
        bf_d       = bf_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        unique case (state_q)
            IDLE: begin
                if (iREQ) begin
                    state_d    = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(T_AS - 1);
                    rs_lat_d   = iRS;
                    // Polling only makes sense on status reads
                    poll_lat_d = iPOLL & ~iRS;
                    pcnt_d     = '0;
                    timeout_d  = 1'b0;
                end
            end
            SETUP: begin
                if (tmr_zero_c) begin
                    state_d  = E_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_EH - 1);
                end
            end
            E_HIGH: begin
                if (tmr_zero_c) begin
                    state_d  = E_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_EL - 1);
                    data_d   = sample_c;
                    if (!rs_lat_q) begin
                        bf_d   = sample_c[BF_BIT];
                        addr_d = sample_c[ADDR_MSB:0];
                    end else begin
                        bf_d   = 1'b0;
                    end
                end
            end
            E_LOW: begin
                if (tmr_zero_c) begin
                    if (poll_lat_q && bf_q && (pcnt_q < PCNT_W'(MAX_POLLS))) begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(T_AS - 1);
                        pcnt_d   = pcnt_q + PCNT_W'(1);
                    end else begin
                        state_d   = DONE;
                        valid_d   = 1'b1;
                        timeout_d = poll_lat_q & bf_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        e_d    = (state_d == E_HIGH);
        rs_d   = busy_d & rs_lat_d;
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            rs_lat_q   <= 1'b0;
            poll_lat_q <= 1'b0;
            data_q     <= '0;
            bf_q       <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            rs_lat_q   <= rs_lat_d;
            poll_lat_q <= poll_lat_d;
            data_q     <= data_d;
            bf_q       <= bf_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
        end
    end

    assign oBUSY    = busy_q;
    assign oVALID   = valid_q;
    assign oDATA    = data_q;
    assign oBF      = bf_q;
    assign oADDR    = addr_q;
    assign oTIMEOUT = timeout_q;
    assign LCD_RW   = busy_q;
    assign LCD_RS   = rs_q;
    assign LCD_E    = e_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every oVALID pulse.
module tb_lcd_read_ctrl;

    logic       CLOCK_50;
    logic       RST;
    logic       iREQ;
    logic       iRS;
    logic       iPOLL;
    logic       oBUSY;
    logic       oVALID;
    logic [7:0] oDATA;
    logic       oBF;
    logic [6:0] oADDR;
    logic       oTIMEOUT;
    logic       LCD_RW;
    logic       LCD_RS;
    logic       LCD_E;
    logic [7:0] bus_drv;
    wire  [7:0] DATA_BUS;

    assign DATA_BUS = bus_drv;

    lcd_read_ctrl #(
        .MAX_POLLS (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .iREQ     (iREQ),
        .iRS      (iRS),
        .iPOLL    (iPOLL),
        .oBUSY    (oBUSY),
        .oVALID   (oVALID),
        .oDATA    (oDATA),
        .oBF      (oBF),
        .oADDR    (oADDR),
        .oTIMEOUT (oTIMEOUT),
        .LCD_RW   (LCD_RW),
        .LCD_RS   (LCD_RS),
        .LCD_E    (LCD_E),
        .DATA_BUS (DATA_BUS)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        bf;
        logic [6:0]  addr;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int unsigned t0;
    int unsigned epulses;
    int unsigned e0;
    logic        e_prev;
    int          total;
    int          bad;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Rising edges of LCD_E seen at negedge sampling
    initial begin
        epulses = 0;
        e_prev  = 1'b0;
    end
    always @(negedge CLOCK_50) begin
        if (LCD_E && !e_prev) epulses++;
        e_prev = LCD_E;
    end

    // Monitor: every result pulse must match the oldest expected entry
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!RST && oVALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(oVALID), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("odata", 32'(oDATA), 32'(e.data));
                chk("obf", 32'(oBF), 32'(e.bf));
                chk("oaddr", 32'(oADDR), 32'(e.addr));
                chk("otimeout", 32'(oTIMEOUT), 32'(e.to));
            end
        end
    end

    task automatic wait_to(input int unsigned n);
        while (cyc < t0 + n) @(negedge CLOCK_50);
    endtask

    task automatic start(input logic rs, input logic poll);
        iREQ  = 1'b1;
        iRS   = rs;
        iPOLL = poll;
        t0    = cyc;
    endtask

    task automatic push(input int unsigned c, input logic [7:0] d, input logic b,
                        input logic [6:0] a, input logic to);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        e.bf   = b;
        e.addr = a;
        e.to   = to;
        exp_q.push_back(e);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        RST     = 1'b1;
        iREQ    = 1'b0;
        iRS     = 1'b0;
        iPOLL   = 1'b0;
        bus_drv = 8'h00;
        t0      = 0;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk("rst_e", 32'(LCD_E), 32'd0);
        chk("rst_rw", 32'(LCD_RW), 32'd0);
        chk("rst_rs", 32'(LCD_RS), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_valid", 32'(oVALID), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        chk("rst_addr", 32'(oADDR), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // Single status read
        bus_drv = 8'h25;
        start(1'b0, 1'b0);
        push(t0 + 58, 8'h25, 1'b0, 7'h25, 1'b0);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        chk("t1_rw_c1", 32'(LCD_RW), 32'd1);
        chk("t1_busy_c1", 32'(oBUSY), 32'd1);
        chk("t1_rs_c1", 32'(LCD_RS), 32'd0);
        wait_to(7);  chk("t1_e_c7", 32'(LCD_E), 32'd0);
        wait_to(8);  chk("t1_e_c8", 32'(LCD_E), 32'd1);
        wait_to(30); chk("t1_e_c30", 32'(LCD_E), 32'd1);
        wait_to(31); chk("t1_e_c31", 32'(LCD_E), 32'd0);
        wait_to(58); chk("t1_rw_c58", 32'(LCD_RW), 32'd1);
        wait_to(59);
        chk("t1_rw_c59", 32'(LCD_RW), 32'd0);
        chk("t1_busy_c59", 32'(oBUSY), 32'd0);
        wait_to(61);

        // Data read: RS high, address untouched
        bus_drv = 8'hA7;
        start(1'b1, 1'b0);
        push(t0 + 58, 8'hA7, 1'b0, 7'h25, 1'b0);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        wait_to(10); chk("t2_rs_c10", 32'(LCD_RS), 32'd1);
        wait_to(60);

        // Poll: busy for three reads, clear on the fourth
        bus_drv = 8'h80;
        e0 = epulses;
        start(1'b0, 1'b1);
        push(t0 + 229, 8'h10, 1'b0, 7'h10, 1'b0);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        wait_to(172);
        bus_drv = 8'h10;
        wait_to(230);
        chk("t3_pulses", epulses - e0, 32'd4);
        chk("t3_busy_end", 32'(oBUSY), 32'd0);

        // Poll exhausted: bus stuck busy
        bus_drv = 8'hFF;
        e0 = epulses;
        start(1'b0, 1'b1);
        push(t0 + 229, 8'hFF, 1'b1, 7'h7F, 1'b1);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        wait_to(230);
        chk("t4_pulses", epulses - e0, 32'd4);

        // Reset in E_HIGH aborts with no result
        bus_drv = 8'h55;
        start(1'b0, 1'b0);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        wait_to(15);
        chk("t5_e_before", 32'(LCD_E), 32'd1);
        RST = 1'b1;
        #1;
        chk("t5_e_abort", 32'(LCD_E), 32'd0);
        chk("t5_rw_abort", 32'(LCD_RW), 32'd0);
        chk("t5_busy_abort", 32'(oBUSY), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        chk("t5_data_rst", 32'(oDATA), 32'd0);
        chk("t5_to_rst", 32'(oTIMEOUT), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        bus_drv = 8'h3C;
        start(1'b0, 1'b0);
        push(t0 + 58, 8'h3C, 1'b0, 7'h3C, 1'b0);
        @(negedge CLOCK_50);
        iREQ = 1'b0;
        wait_to(60);

        // Request held high: back-to-back with one IDLE cycle between
        bus_drv = 8'h9A;
        start(1'b1, 1'b0);
        push(t0 + 58, 8'h9A, 1'b0, 7'h3C, 1'b0);
        push(t0 + 117, 8'h9A, 1'b0, 7'h3C, 1'b0);
        wait_to(58); chk("t6_busy_c58", 32'(oBUSY), 32'd1);
        wait_to(59);
        chk("t6_busy_c59", 32'(oBUSY), 32'd0);
        chk("t6_rw_c59", 32'(LCD_RW), 32'd0);
        wait_to(60);
        chk("t6_busy_c60", 32'(oBUSY), 32'd1);
        chk("t6_rs_c60", 32'(LCD_RS), 32'd1);
        iREQ = 1'b0;
        wait_to(118);
        chk("t6_busy_c118", 32'(oBUSY), 32'd0);
        wait_to(121);

        chk("pending_results", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_read_ctrl.md
Name: lcd_read_ctrl

Overview:
- HD44780-style LCD bus reader: the read-side counterpart of the LCD_Display write driver.
- Performs single read cycles (LCD_RW=1): status/address read (RS=0) or DDRAM/CGRAM data read (RS=1).
- Busy-flag poll mode re-reads status until BF=0, so the writer can gate commands on the real busy flag instead of fixed delays.
- Instantiated beside LCD_Display in lcdlab3-style top levels; the top muxes LCD_RW/LCD_RS/LCD_E ownership via oBUSY.

Parameters:
T_AS, 7, cycles RS/RW setup before E rises (≥140 ns at 50 MHz)
T_EH, 23, cycles E held high (≥450 ns); DATA_BUS sampled on last cycle
T_EL, 27, cycles E low after fall, RW/RS held (completes ≥1 µs cycle)
MAX_POLLS, 1023, max status reads in poll mode before timeout

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RST  in  1  asynchronous reset, active-high
iREQ  in  1  start request, sampled only in IDLE
iRS  in  1  register select for request (0=status, 1=data); latched on accept
iPOLL  in  1  poll mode (only meaningful with iRS=0); latched on accept
oBUSY  in/out: out  1  transaction in progress, bus owned by reader
oVALID  out  1  one-cycle pulse, result registers valid
oDATA  out  8  last byte sampled from DATA_BUS
oBF  out  1  oDATA[7] when RS=0 read, else 0
oADDR  out  7  oDATA[6:0] when RS=0 read, else held
oTIMEOUT  out  1  set with oVALID when poll exhausted MAX_POLLS
LCD_RW  out  1  1 during transaction, else 0
LCD_RS  out  1  latched iRS during transaction, else 0
LCD_E  out  1  enable strobe
DATA_BUS  inout  8  never driven by this block (constant high-Z); input only

Behaviour:
- Reset (async, RST=1): state IDLE; LCD_E=0, LCD_RW=0, LCD_RS=0, oBUSY=0, oVALID=0, oTIMEOUT=0, oDATA=0, oBF=0, oADDR=0, poll count=0. Reset mid-cycle aborts immediately, E drops the same instant, no oVALID.
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- Cycle 0: IDLE with iREQ=1 → accept; latch iRS/iPOLL; from cycle 1: SETUP, oBUSY=1, LCD_RW=1, LCD_RS=latched.
- SETUP lasts T_AS cycles, then E_HIGH (LCD_E=1) lasts T_EH cycles; on its last cycle register DATA_BUS into oDATA (update oBF/oADDR if RS=0).
- E_LOW lasts T_EL cycles, LCD_E=0, RW/RS held.
- After E_LOW: if poll mode, BF=1 and poll count < MAX_POLLS → count++ and re-enter SETUP (no gap); else DONE.
- DONE: 1 cycle, oVALID=1, oTIMEOUT=(poll mode & BF=1); next cycle IDLE, oBUSY=0, LCD_RW=0, LCD_RS=0, poll count cleared.
- Defaults: E rises cycle 8, falls cycle 31, oVALID cycle 58; each extra poll read adds T_AS+T_EH+T_EL=57 cycles.
- iREQ while oBUSY=1 ignored (not queued). iREQ high in the DONE cycle also ignored; acceptance needs IDLE.
- iPOLL with iRS=1: treated as single read.
- oDATA/oBF/oADDR hold value until next sample; oTIMEOUT holds until next accept.
- Poll count width = clog2(MAX_POLLS+1); no wrap possible.

Optional Feature:
LCD_READ_SYNC_EN: defined → DATA_BUS passes a 2-flop synchroniser; sample point moves to the last E_HIGH cycle of the synchronised copy, so the value captured is DATA_BUS as seen 2 cycles earlier. T_EH must be ≥3 (elaborate-time check). Undefined → direct capture, as above.

Decomposition:
- Package lcd_pkg: state enum (IDLE..DONE), default timing constants for 50 MHz, BF bit index 7, address field [6:0].
- Sub-module lcd_timer: loadable down-counter with zero flag, shared by all timed states. Width = clog2(max(T_AS,T_EH,T_EL)+1).

Test Plan:
- Single status read, DATA_BUS=8'h25 held → LCD_E high cycles 8..30, oVALID at cycle 58, oDATA=25, oBF=0, oADDR=7'h25, LCD_RW=1 cycles 1..58.
- Data read iRS=1, DATA_BUS=8'hA7 → oDATA=A7, oBF=0, LCD_RS=1 during transaction, oADDR unchanged.
- Poll, bus=8'h80 for first 3 reads then 8'h10 → 4 E pulses, oVALID at cycle 1+4×57, oBF=0, oADDR=10, oTIMEOUT=0.
- Poll with MAX_POLLS=3, bus stuck 8'hFF → 4 reads, oVALID with oTIMEOUT=1, oBF=1.
- RST pulse during E_HIGH → LCD_E=0 immediately, no oVALID; new iREQ afterward completes normally at cycle 58.
- iREQ held high continuously → back-to-back transactions, each accepted only in IDLE, 1-cycle IDLE gap between oVALID and next SETUP.
